i2s_rx_deser: RTL and testbench
===============================

Name: i2s_rx_deser

Overview:
- Oversampled I2S receiver; samples the ADC serial bus (bit clock, word clock, serial data) in the 50 MHz system clock domain.
- Emits one parallel left/right sample pair per frame, with a single-cycle valid strobe.
- Sits directly downstream of the ADC pins and i2s_test_gen inside mojo_top.
- Feeds the DSP datapath and the DAC serializer.

Parameters:
- DATA_W, 24: sample width captured per channel, MSB first.
- SYNC_STAGES, 2: synchronizer flops on each serial input, minimum 2.
- LRCK_LEFT_LVL, 0: synchronized word-clock level denoting the left channel.

Ports:
- clk  input  1  50 MHz system clock.
- rst_n  input  1  asynchronous active-low reset.
- i_bck  input  1  I2S bit clock, asynchronous to clk.
- i_lrck  input  1  I2S word clock, asynchronous.
- i_adata  input  1  I2S serial data, asynchronous.
- o_left  output  DATA_W  last complete left sample, two's complement.
- o_right  output  DATA_W  last complete right sample, two's complement.
- o_valid  output  1  one-clk strobe: o_left/o_right updated.
- o_locked  output  1  high once a full left+right frame has been captured.
- o_frame_err  output  1  one-clk strobe: word clock toggled before DATA_W bits were captured.

Behaviour:
- Reset: all outputs 0, state HUNT, bit counter 0, holding register 0, synchronizers 0. Reset mid-word discards the partial word; no o_valid follows.
- Synchronization: i_bck, i_lrck and i_adata each pass through SYNC_STAGES flops. bck_rise = synced bck high AND previous synced bck low, a single clk-cycle event. All further logic acts only in bck_rise cycles. The bit clock high and low phases must each be at least 3 clk periods.
- Word-clock edge: on each bck_rise, compare the synced lrck with the lrck captured at the previous bck_rise. A difference marks this bit as the I2S one-bit delay slot, and that bit is discarded.
- States:
  - HUNT: ignore data until the first word-clock edge, then go to SHIFT with count 0. The channel is set from the new lrck level.
  - SHIFT: on each bck_rise without a word-clock edge, shift i_adata into the shift register MSB-first and increment the count. When count reaches DATA_W, go to PAD.
  - PAD: ignore remaining slot bits. On a word-clock edge, go to SHIFT with count 0, channel from the new lrck level.
- SHIFT interrupted: a word-clock edge while in SHIFT with count < DATA_W gives o_frame_err = 1 for one clk. The partial word is discarded and no output updates. Go to SHIFT with count 0 for the new channel, and clear o_locked.
- Left word complete: the word enters the holding register. Nothing is output.
- Right word complete: o_left gets the holding register, o_right gets the shifted word, and o_valid = 1. Both updates happen on the clk edge after the bck_rise cycle of the final bit. o_locked is set when the holding register was filled in the same lock epoch.
- Right word with no preceding left since HUNT or error: o_right updates only, no o_valid.
- Latency: o_valid is high exactly SYNC_STAGES+2 clk edges after the raw i_bck rising edge that carries the final right-channel bit.
- Outputs hold between strobes.
- A slot longer than DATA_W bits is legal; the excess bits are ignored in PAD.
- A slot of exactly DATA_W+1 bck periods is legal: the next edge arrives while in PAD.

Optional Feature:
- Macro: I2S_RX_ERRCNT_EN.
- Defined: adds port o_err_cnt (output, 8 bits). It increments on every o_frame_err, saturates at 255, and resets to 0 only on rst_n.
- Undefined: the port and counter are absent. o_frame_err behaviour is unchanged.

Test Plan:
- Nominal frame: DATA_W=24, 32-bit slots, bck half-period 177 ns, left=24'h123456, right=24'hABCDEF → o_left=24'h123456, o_right=24'hABCDEF. o_valid is one clk wide, SYNC_STAGES+2 clk edges after the last right bit's raw bck rise. o_locked=1.
- Startup mid-frame: release reset halfway through a right slot → no o_valid or o_frame_err for that slot. The first o_valid comes at the end of the next complete right slot.
- Short slot: word clock toggles after 10 left bits → o_frame_err pulse, o_locked=0, no o_valid. The next full left+right pair (24'h000001 / 24'hFFFFFF) gives o_valid with those values, and o_locked=1.
- Negative full-scale and sign: left=24'h800000, right=24'h7FFFFF → outputs match exactly. The captured word is the DATA_W bits immediately after the delay bit, with no bit shift.
- Reset mid-operation: assert rst_n low during the 12th right bit → all outputs 0 immediately (asynchronous). After release, behaviour resumes as in the startup case.
- Error counter (I2S_RX_ERRCNT_EN defined): inject 300 short slots → o_err_cnt=255 and held. Reset → 0.

Source files
------------

// File: rtl/i2s_rx_deser.sv
// i2s_rx_deser: oversampled I2S receiver. Samples bit clock, word clock and
// serial data in the clk domain. Emits one left/right sample pair per frame
// with a one-cycle valid strobe.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   i_bck           I2S bit clock (asynchronous)
//   i_lrck          I2S word clock (asynchronous)
//   i_adata         I2S serial data (asynchronous)
//   o_left/o_right  last complete sample pair, two's complement
//   o_valid         one-cycle strobe, o_left/o_right updated
//   o_locked        a full left+right frame has been captured since the last error/reset
//   o_frame_err     one-cycle strobe, word clock toggled mid-word
//   o_err_cnt       saturating frame-error count (only with I2S_RX_ERRCNT_EN)
//
// Optional feature macro: I2S_RX_ERRCNT_EN adds o_err_cnt.
module i2s_rx_deser #(
    parameter int unsigned DATA_W        = 24,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          LRCK_LEFT_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_bck,
    input  logic              i_lrck,
    input  logic              i_adata,
    output logic [DATA_W-1:0] o_left,
    output logic [DATA_W-1:0] o_right,
    output logic              o_valid,
    output logic              o_locked,
`ifdef I2S_RX_ERRCNT_EN
    output logic              o_frame_err,
    output logic [7:0]        o_err_cnt
`else
    output logic              o_frame_err
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAD   = 2'd2
    } state_t;

    // Synchronizer chains, newest sample in bit 0
    logic [SYNC_STAGES-1:0] bck_sync_q, bck_sync_d;
    logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
    logic [SYNC_STAGES-1:0] adata_sync_q, adata_sync_d;

    // Registered bit-clock rise with lrck/data sampled in the same cycle
    logic bck_dly_q, bck_dly_d;
    logic rise_q, rise_d;
    logic lrck_smp_q, lrck_smp_d;
    logic adata_smp_q, adata_smp_d;

    // Word-clock edge tracking; primed_q masks the first rise after reset
    logic primed_q, primed_d;
    logic lrck_prev_q, lrck_prev_d;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              chan_right_q, chan_right_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;

    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              valid_q, valid_d;
    logic              locked_q, locked_d;
    logic              ferr_q, ferr_d;

`ifdef I2S_RX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
`endif

    logic              ws_edge;
    logic              new_right;
    logic [DATA_W-1:0] shreg_nxt;

    // Next-state and output computation
    always_comb begin
        bck_sync_d   = {bck_sync_q[SYNC_STAGES-2:0], i_bck};
        lrck_sync_d  = {lrck_sync_q[SYNC_STAGES-2:0], i_lrck};
        adata_sync_d = {adata_sync_q[SYNC_STAGES-2:0], i_adata};
        bck_dly_d    = bck_sync_q[SYNC_STAGES-1];
        rise_d       = bck_sync_q[SYNC_STAGES-1] & ~bck_dly_q;
        lrck_smp_d   = lrck_sync_q[SYNC_STAGES-1];
        adata_smp_d  = adata_sync_q[SYNC_STAGES-1];

        primed_d     = primed_q;
        lrck_prev_d  = lrck_prev_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        chan_right_d = chan_right_q;
        shreg_d      = shreg_q;
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        left_d       = left_q;
        right_d      = right_q;
        locked_d     = locked_q;
        valid_d      = 1'b0;
        ferr_d       = 1'b0;

        ws_edge   = primed_q & (lrck_smp_q ^ lrck_prev_q);
        new_right = lrck_smp_q ^ LRCK_LEFT_LVL;
        shreg_nxt = {shreg_q[DATA_W-2:0], adata_smp_q};

        if (rise_q) begin
            primed_d    = 1'b1;
            lrck_prev_d = lrck_smp_q;
            case (state_q)
                ST_HUNT: begin
                    if (ws_edge) begin
                        state_d      = ST_SHIFT;
                        cnt_d        = '0;
                        chan_right_d = new_right;
                    end
                end
                ST_SHIFT: begin
                    if (ws_edge) begin
                        // Word clock moved before the word filled: drop it, restart
                        ferr_d       = 1'b1;
                        locked_d     = 1'b0;
                        hold_vld_d   = 1'b0;
                        cnt_d        = '0;
                        chan_right_d = new_right;
                    end else begin
                        shreg_d = shreg_nxt;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d = ST_PAD;
                            cnt_d   = CNT_W'(DATA_W);
                            if (!chan_right_q) begin
                                hold_d     = shreg_nxt;
                                hold_vld_d = 1'b1;
                            end else begin
                                right_d = shreg_nxt;
                                // Pair is only emitted when a left word of this epoch is held
                                if (hold_vld_q) begin
                                    left_d     = hold_q;
                                    valid_d    = 1'b1;
                                    locked_d   = 1'b1;
                                    hold_vld_d = 1'b0;
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_PAD: begin
                    if (ws_edge) begin
                        state_d      = ST_SHIFT;
                        cnt_d        = '0;
                        chan_right_d = new_right;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    cnt_d   = '0;
                end
            endcase
        end

`ifdef I2S_RX_ERRCNT_EN
        err_cnt_d = err_cnt_q;
        if (ferr_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_sync_q   <= '0;
            lrck_sync_q  <= '0;
            adata_sync_q <= '0;
            bck_dly_q    <= 1'b0;
            rise_q       <= 1'b0;
            lrck_smp_q   <= 1'b0;
            adata_smp_q  <= 1'b0;
            primed_q     <= 1'b0;
            lrck_prev_q  <= 1'b0;
            state_q      <= ST_HUNT;
            cnt_q        <= '0;
            chan_right_q <= 1'b0;
            shreg_q      <= '0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
            valid_q      <= 1'b0;
            locked_q     <= 1'b0;
            ferr_q       <= 1'b0;
`ifdef I2S_RX_ERRCNT_EN
            err_cnt_q    <= '0;
`endif
        end else begin
            bck_sync_q   <= bck_sync_d;
            lrck_sync_q  <= lrck_sync_d;
            adata_sync_q <= adata_sync_d;
            bck_dly_q    <= bck_dly_d;
            rise_q       <= rise_d;
            lrck_smp_q   <= lrck_smp_d;
            adata_smp_q  <= adata_smp_d;
            primed_q     <= primed_d;
            lrck_prev_q  <= lrck_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            chan_right_q <= chan_right_d;
            shreg_q      <= shreg_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            left_q       <= left_d;
            right_q      <= right_d;
            valid_q      <= valid_d;
            locked_q     <= locked_d;
            ferr_q       <= ferr_d;
`ifdef I2S_RX_ERRCNT_EN
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    assign o_left      = left_q;
    assign o_right     = right_q;
    assign o_valid     = valid_q;
    assign o_locked    = locked_q;
    assign o_frame_err = ferr_q;
`ifdef I2S_RX_ERRCNT_EN
    assign o_err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Testbench for i2s_rx_deser: drives I2S frames slot by slot and predicts,
// from the transmitted words and slot lengths, which outputs must appear and
// on which clk cycle. A compare process checks every cycle.
`timescale 1ns/100ps
module tb_i2s_rx_deser;

    localparam int unsigned DATA_W      = 24;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          LAT         = SYNC_STAGES + 2;
    localparam bit          LEFT_LVL    = 1'b0;
    localparam real         HALF        = 177.0;

    localparam int EV_VALID = 0;
    localparam int EV_RONLY = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int                cyc;
        int                kind;
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } ev_t;

    logic              clk;
    logic              rst_n;
    logic              i_bck;
    logic              i_lrck;
    logic              i_adata;
    logic [DATA_W-1:0] o_left;
    logic [DATA_W-1:0] o_right;
    logic              o_valid;
    logic              o_locked;
    logic              o_frame_err;
`ifdef I2S_RX_ERRCNT_EN
    logic [7:0]        o_err_cnt;
`endif

    i2s_rx_deser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_bck       (i_bck),
        .i_lrck      (i_lrck),
        .i_adata     (i_adata),
        .o_left      (o_left),
        .o_right     (o_right),
        .o_valid     (o_valid),
        .o_locked    (o_locked),
`ifdef I2S_RX_ERRCNT_EN
        .o_frame_err (o_frame_err),
        .o_err_cnt   (o_err_cnt)
`else
        .o_frame_err (o_frame_err)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model state (frame level)
    ev_t               evq[$];
    bit                m_primed, m_last_right, m_capt, m_chan_right, m_hold_ok;
    int                m_nbits;
    logic [DATA_W-1:0] m_word, m_hold;
    int                right_done_cyc;

    // Expected held outputs
    logic [DATA_W-1:0] x_left, x_right;
    bit                x_locked, x_valid, x_ferr;
    int                x_cnt;
    int                n_valid, n_ferr, valid_cyc;
    ev_t               ev;

    task automatic push_ev(input int kind, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        ev_t e;
        e.cyc  = cyc + LAT;
        e.kind = kind;
        e.l    = l;
        e.r    = r;
        evq.push_back(e);
    endtask

    task automatic model_reset();
        m_primed  = 1'b0;
        m_capt    = 1'b0;
        m_hold_ok = 1'b0;
        m_nbits   = 0;
        evq.delete();
        x_left    = '0;
        x_right   = '0;
        x_locked  = 1'b0;
        x_cnt     = 0;
    endtask

    // Called at each raw bck rise seen by an out-of-reset receiver
    task automatic model_bit(input bit right, input logic [DATA_W-1:0] word);
        if (m_primed && (right != m_last_right)) begin
            if (m_capt) begin
                push_ev(EV_ERR, '0, '0);
                m_hold_ok = 1'b0;
            end
            m_capt       = 1'b1;
            m_nbits      = 0;
            m_chan_right = right;
            m_word       = word;
        end else if (m_capt) begin
            m_nbits = m_nbits + 1;
            if (m_nbits == DATA_W) begin
                m_capt = 1'b0;
                if (!m_chan_right) begin
                    m_hold    = m_word;
                    m_hold_ok = 1'b1;
                end else if (m_hold_ok) begin
                    push_ev(EV_VALID, m_hold, m_word);
                    m_hold_ok      = 1'b0;
                    right_done_cyc = cyc;
                end else begin
                    push_ev(EV_RONLY, '0, m_word);
                end
            end
        end
        m_primed     = 1'b1;
        m_last_right = right;
    endtask

    // Sends one slot: bit 0 is the delay bit, bits 1..DATA_W the word MSB first.
    // rst_at: assert reset mid-high of that bit; rel_at: release reset before that bit.
    task automatic send_slot(input bit right, input logic [DATA_W-1:0] word, input int nbits,
                             input int rst_at, input int rel_at);
        for (int i = 0; i < nbits; i++) begin
            i_lrck = right ^ LEFT_LVL;
            if (i >= 1 && i <= DATA_W) i_adata = word[DATA_W-i];
            else                       i_adata = 1'($urandom_range(0, 1));
            if (i == rel_at) rst_n = 1'b1;
            #(HALF);
            i_bck = 1'b1;
            if (rst_n) model_bit(right, word);
            if (i == rst_at) begin
                #(88.0);
                rst_n = 1'b0;
                model_reset();
                #(1.0);
                chk("rst_async_left",  32'(o_left), 32'h0);
                chk("rst_async_right", 32'(o_right), 32'h0);
                chk("rst_async_valid", 32'(o_valid), 32'h0);
                chk("rst_async_lock",  32'(o_locked), 32'h0);
                #(HALF - 89.0);
            end else begin
                #(HALF);
            end
            i_bck = 1'b0;
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        x_valid = 1'b0;
        x_ferr  = 1'b0;
        if (evq.size() != 0 && evq[0].cyc < cyc) begin
            ev = evq.pop_front();
            chk("event_missed", 32'(ev.cyc), 32'(cyc));
        end
        if (evq.size() != 0 && evq[0].cyc == cyc) begin
            ev = evq.pop_front();
            case (ev.kind)
                EV_VALID: begin
                    x_valid  = 1'b1;
                    x_left   = ev.l;
                    x_right  = ev.r;
                    x_locked = 1'b1;
                end
                EV_RONLY: x_right = ev.r;
                default: begin
                    x_ferr   = 1'b1;
                    x_locked = 1'b0;
                    if (x_cnt < 255) x_cnt = x_cnt + 1;
                end
            endcase
        end
        chk("cyc_valid",  32'(o_valid), 32'(x_valid));
        chk("cyc_ferr",   32'(o_frame_err), 32'(x_ferr));
        chk("cyc_left",   32'(o_left), 32'(x_left));
        chk("cyc_right",  32'(o_right), 32'(x_right));
        chk("cyc_locked", 32'(o_locked), 32'(x_locked));
`ifdef I2S_RX_ERRCNT_EN
        chk("cyc_errcnt", 32'(o_err_cnt), 32'(x_cnt));
`endif
        if (o_valid) begin
            n_valid   = n_valid + 1;
            valid_cyc = cyc;
        end
        if (o_frame_err) n_ferr = n_ferr + 1;
    end

    initial begin
        #(2ms);
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    int v0, f0;
    logic [DATA_W-1:0] lw, rw;
    bit short_l, short_r;

    initial begin
        n_valid = 0;
        n_ferr  = 0;
        valid_cyc = 0;
        right_done_cyc = 0;
        rst_n   = 1'b0;
        i_bck   = 1'b0;
        i_lrck  = 1'b0;
        i_adata = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        #(3.5);

        chk("reset_left",  32'(o_left), 32'h0);
        chk("reset_right", 32'(o_right), 32'h0);
        chk("reset_valid", 32'(o_valid), 32'h0);
        chk("reset_lock",  32'(o_locked), 32'h0);
        chk("reset_ferr",  32'(o_frame_err), 32'h0);

        // Startup halfway through a right slot, then nominal frame
        send_slot(1'b1, 24'($urandom), 32, -1, 16);
        chk("startup_no_valid", 32'(n_valid), 32'd0);
        chk("startup_no_ferr",  32'(n_ferr), 32'd0);
        send_slot(1'b0, 24'h123456, 32, -1, -1);
        send_slot(1'b1, 24'hABCDEF, 32, -1, -1);
        chk("nom_left",    32'(o_left), 32'h123456);
        chk("nom_right",   32'(o_right), 32'hABCDEF);
        chk("nom_lock",    32'(o_locked), 32'h1);
        chk("nom_nvalid",  32'(n_valid), 32'd1);
        chk("nom_latency", 32'(valid_cyc - right_done_cyc), 32'd4);

        // Short left slot (10 data bits)
        v0 = n_valid;
        f0 = n_ferr;
        send_slot(1'b0, 24'($urandom), 11, -1, -1);
        send_slot(1'b1, 24'($urandom), 32, -1, -1);
        chk("short_ferr",     32'(n_ferr - f0), 32'd1);
        chk("short_unlocked", 32'(o_locked), 32'h0);
        chk("short_no_valid", 32'(n_valid - v0), 32'd0);
        send_slot(1'b0, 24'h000001, 32, -1, -1);
        send_slot(1'b1, 24'hFFFFFF, 32, -1, -1);
        chk("recover_left",  32'(o_left), 32'h000001);
        chk("recover_right", 32'(o_right), 32'hFFFFFF);
        chk("recover_lock",  32'(o_locked), 32'h1);
        chk("recover_valid", 32'(n_valid - v0), 32'd1);

        // Full-scale values in minimum-length (DATA_W+1) slots
        send_slot(1'b0, 24'h800000, 25, -1, -1);
        send_slot(1'b1, 24'h7FFFFF, 25, -1, -1);
        chk("sign_left",  32'(o_left), 32'h800000);
        chk("sign_right", 32'(o_right), 32'h7FFFFF);

        // Reset during the 12th right bit, resume afterwards
        send_slot(1'b0, 24'($urandom), 32, -1, -1);
        v0 = n_valid;
        send_slot(1'b1, 24'($urandom), 32, 12, 14);
        chk("rstmid_no_valid", 32'(n_valid - v0), 32'd0);
        send_slot(1'b0, 24'h5A5A5A, 32, -1, -1);
        send_slot(1'b1, 24'h0F0F0F, 32, -1, -1);
        chk("rstmid_left",  32'(o_left), 32'h5A5A5A);
        chk("rstmid_right", 32'(o_right), 32'h0F0F0F);
        chk("rstmid_valid", 32'(n_valid - v0), 32'd1);

        // Randomized frames, occasional short slots
        for (int k = 0; k < 16; k++) begin
            lw = 24'($urandom);
            rw = 24'($urandom);
            short_l = ($urandom_range(0, 7) == 0);
            short_r = ($urandom_range(0, 7) == 0);
            send_slot(1'b0, lw, short_l ? $urandom_range(2, 24) : $urandom_range(25, 32), -1, -1);
            send_slot(1'b1, rw, short_r ? $urandom_range(2, 24) : $urandom_range(25, 32), -1, -1);
        end
        send_slot(1'b0, 24'($urandom), 32, -1, -1);
        send_slot(1'b1, 24'($urandom), 32, -1, -1);

`ifdef I2S_RX_ERRCNT_EN
        // 300 short slots drive the error counter into saturation
        for (int k = 0; k < 300; k++) begin
            send_slot(k[0], 24'($urandom), 2, -1, -1);
        end
        send_slot(1'b0, 24'($urandom), 32, -1, -1);
        send_slot(1'b1, 24'($urandom), 32, -1, -1);
        chk("errcnt_sat", 32'(o_err_cnt), 32'd255);
        rst_n = 1'b0;
        model_reset();
        #(1.0);
        chk("errcnt_rst", 32'(o_err_cnt), 32'd0);
        #(100.0);
        rst_n = 1'b1;
`endif

        repeat (10) @(posedge clk);
        chk("evq_drained", 32'(evq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
